// File: rtl/uart_pkg.sv
// Definitions shared by the UART receive path and the matching frame transmitter:
// byte FSM states, parity modes, baud constant and the parity check.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    // 50 MHz system clock, 9600 baud
    localparam int BAUD_CLKS_50M_9600 = 5208;

    // Even mode wants data^parity == 0, odd mode wants it == 1.
    function automatic logic parity_ok(input logic [7:0] data, input logic par_bit, input int mode);
        return ((^data) ^ par_bit) == (mode == PARITY_ODD);
    endfunction

endpackage

// File: rtl/uart_frame_rx_if.sv
// Serial input and frame-level outputs of the frame receiver, plus its byte FSM
// state for observation. master = receiver side, slave = consumer side.
interface uart_frame_rx_if #(
    parameter int BYTES_PER_FRAME = 2
);
    import uart_pkg::*;

    logic                         rx_serial;
    logic [8*BYTES_PER_FRAME-1:0] frame_data;
    logic                         frame_valid;
    logic                         framing_error;
    logic                         parity_error;
    logic                         timeout_error;
    logic                         busy;
    uart_state_e                  dbg_state;

    // All outputs are single-cycle registered pulses except frame_data (held
    // until the next good frame), busy (level) and dbg_state (level).
    modport master (
        input  rx_serial,
        output frame_data, frame_valid, framing_error, parity_error,
        output timeout_error, busy, dbg_state
    );

    modport slave (
        output rx_serial,
        input  frame_data, frame_valid, framing_error, parity_error,
        input  timeout_error, busy, dbg_state
    );

endinterface

// File: rtl/uart_rx_byte.sv
// Single-byte UART deserialiser: 2-flop synchroniser, start-bit glitch filter,
// 8 data bits LSB first, optional parity bit and a mid-bit stop sample.
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int CLOCKS_PER_BIT = BAUD_CLKS_50M_9600,
    parameter int PARITY_MODE    = PARITY_NONE
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        rx_serial,
    output logic        byte_done,
    output logic [7:0]  byte_data,
    output logic        frame_err,
    output logic        par_err,
    output logic        start_fire,
    output logic        glitch_fire,
    output uart_state_e state
);

    localparam int TW = $clog2(CLOCKS_PER_BIT);
    localparam logic [TW-1:0] HALF_M1 = TW'(CLOCKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] FULL_M1 = TW'(CLOCKS_PER_BIT - 1);

    uart_state_e   state_q, state_d;
    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          prev_q, prev_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_bad_q, par_bad_d;
    logic          byte_done_q, byte_done_d;
    logic [7:0]    byte_data_q, byte_data_d;
    logic          frame_err_q, frame_err_d;
    logic          par_err_q, par_err_d;

    always_comb begin
        state_d     = state_q;
        sync1_d     = rx_serial;
        sync2_d     = sync1_q;
        prev_d      = sync2_q;
        timer_d     = timer_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        par_bad_d   = par_bad_q;
        byte_done_d = 1'b0;
        byte_data_d = byte_data_q;
        frame_err_d = 1'b0;
        par_err_d   = 1'b0;
        start_fire  = 1'b0;
        glitch_fire = 1'b0;

        case (state_q)
            IDLE: begin
                if (prev_q && !sync2_q) begin
                    start_fire = 1'b1;
                    state_d    = START;
                    timer_d    = '0;
                end
            end
            START: begin
                if (timer_q == HALF_M1) begin
                    timer_d = '0;
                    // A line that is high again at mid start-bit was noise.
                    if (sync2_q) begin
                        glitch_fire = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                        par_bad_d = 1'b0;
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            DATA: begin
                if (timer_q == FULL_M1) begin
                    timer_d = '0;
                    shift_d = {sync2_q, shift_q[7:1]};
                    if (bit_cnt_q == 3'd7) begin
                        state_d = (PARITY_MODE != PARITY_NONE) ? PARITY : STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            PARITY: begin
                if (timer_q == FULL_M1) begin
                    timer_d   = '0;
                    par_bad_d = !parity_ok(shift_q, sync2_q, PARITY_MODE);
                    state_d   = STOP;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            STOP: begin
                // Leave at mid stop-bit so the next start edge can arrive early.
                if (timer_q == FULL_M1) begin
                    timer_d     = '0;
                    state_d     = IDLE;
                    byte_done_d = 1'b1;
                    byte_data_d = shift_q;
                    frame_err_d = !sync2_q;
                    par_err_d   = par_bad_q;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            prev_q      <= 1'b1;
            timer_q     <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            par_bad_q   <= 1'b0;
            byte_done_q <= 1'b0;
            byte_data_q <= '0;
            frame_err_q <= 1'b0;
            par_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            prev_q      <= prev_d;
            timer_q     <= timer_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            par_bad_q   <= par_bad_d;
            byte_done_q <= byte_done_d;
            byte_data_q <= byte_data_d;
            frame_err_q <= frame_err_d;
            par_err_q   <= par_err_d;
        end
    end

    assign byte_done = byte_done_q;
    assign byte_data = byte_data_q;
    assign frame_err = frame_err_q;
    assign par_err   = par_err_q;
    assign state     = state_q;

endmodule

// File: rtl/uart_frame_rx.sv
// Multi-byte UART frame receiver: collects BYTES_PER_FRAME good bytes into one
// frame, reports byte errors and discards partial frames on inter-byte timeout.
module uart_frame_rx
    import uart_pkg::*;
#(
    parameter int CLOCKS_PER_BIT  = BAUD_CLKS_50M_9600,
    parameter int BYTES_PER_FRAME = 2,
    parameter int PARITY_MODE     = PARITY_NONE,
    parameter int TIMEOUT_BITS    = 20
) (
    input  logic            clock,
    input  logic            reset,
    uart_frame_rx_if.master bus
);

    localparam int FW       = 8 * BYTES_PER_FRAME;
    localparam int IW       = $clog2(BYTES_PER_FRAME + 1);
    localparam int TO_LIMIT = TIMEOUT_BITS * CLOCKS_PER_BIT;
    localparam int CW       = $clog2(TO_LIMIT + 1);

    logic        rx_done;
    logic [7:0]  rx_byte;
    logic        rx_frame_err;
    logic        rx_par_err;
    logic        rx_start;
    logic        rx_glitch;
    uart_state_e rx_state;

    uart_rx_byte #(
        .CLOCKS_PER_BIT (CLOCKS_PER_BIT),
        .PARITY_MODE    (PARITY_MODE)
    ) u_byte (
        .clock       (clock),
        .reset       (reset),
        .rx_serial   (bus.rx_serial),
        .byte_done   (rx_done),
        .byte_data   (rx_byte),
        .frame_err   (rx_frame_err),
        .par_err     (rx_par_err),
        .start_fire  (rx_start),
        .glitch_fire (rx_glitch),
        .state       (rx_state)
    );

    logic [FW-1:0] shift_q, shift_d;
    logic [FW-1:0] frame_data_q, frame_data_d;
    logic [IW-1:0] byte_index_q, byte_index_d;
    logic [CW-1:0] to_cnt_q, to_cnt_d;
    logic          frame_valid_q, frame_valid_d;
    logic          framing_error_q, framing_error_d;
    logic          parity_error_q, parity_error_d;
    logic          timeout_error_q, timeout_error_d;
    logic          busy_q, busy_d;

    always_comb begin
        shift_d         = shift_q;
        frame_data_d    = frame_data_q;
        byte_index_d    = byte_index_q;
        to_cnt_d        = to_cnt_q;
        frame_valid_d   = 1'b0;
        framing_error_d = 1'b0;
        parity_error_d  = 1'b0;
        timeout_error_d = 1'b0;
        busy_d          = busy_q;

        if (rx_done) begin
            to_cnt_d = '0;
            if (rx_frame_err || rx_par_err) begin
                framing_error_d = rx_frame_err;
                parity_error_d  = rx_par_err;
                byte_index_d    = '0;
            end else begin
                shift_d = FW'({shift_q, rx_byte});
                if (byte_index_q == IW'(BYTES_PER_FRAME - 1)) begin
                    frame_data_d  = shift_d;
                    frame_valid_d = 1'b1;
                    byte_index_d  = '0;
                end else begin
                    byte_index_d = byte_index_q + IW'(1);
                end
            end
        end else if (rx_state == IDLE && byte_index_q != '0) begin
            // Only the gaps between bytes of a partial frame are timed.
            if (to_cnt_q == CW'(TO_LIMIT - 1)) begin
                timeout_error_d = 1'b1;
                byte_index_d    = '0;
                to_cnt_d        = '0;
            end else begin
                to_cnt_d = to_cnt_q + CW'(1);
            end
        end

        // A start edge wins over any same-cycle end-of-frame event.
        if (rx_start) begin
            busy_d = 1'b1;
        end else if (frame_valid_d || framing_error_d || parity_error_d || timeout_error_d) begin
            busy_d = 1'b0;
        end else if (rx_glitch && byte_index_q == '0) begin
            busy_d = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shift_q         <= '0;
            frame_data_q    <= '0;
            byte_index_q    <= '0;
            to_cnt_q        <= '0;
            frame_valid_q   <= 1'b0;
            framing_error_q <= 1'b0;
            parity_error_q  <= 1'b0;
            timeout_error_q <= 1'b0;
            busy_q          <= 1'b0;
        end else begin
            shift_q         <= shift_d;
            frame_data_q    <= frame_data_d;
            byte_index_q    <= byte_index_d;
            to_cnt_q        <= to_cnt_d;
            frame_valid_q   <= frame_valid_d;
            framing_error_q <= framing_error_d;
            parity_error_q  <= parity_error_d;
            timeout_error_q <= timeout_error_d;
            busy_q          <= busy_d;
        end
    end

    assign bus.frame_data    = frame_data_q;
    assign bus.frame_valid   = frame_valid_q;
    assign bus.framing_error = framing_error_q;
    assign bus.parity_error  = parity_error_q;
    assign bus.timeout_error = timeout_error_q;
    assign bus.busy          = busy_q;
    assign bus.dbg_state     = rx_state;

endmodule

// File: tb/tb_uart_frame_rx.sv
// Directed bench for uart_frame_rx: one 8N1 receiver and one 8E1 receiver
// sharing clock and reset, with per-receiver pulse monitors.
module tb_uart_frame_rx;
    import uart_pkg::*;

    localparam int CPB = 8;
    localparam int NB  = 2;
    localparam int TO  = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    uart_frame_rx_if #(.BYTES_PER_FRAME(NB)) bus0 ();
    uart_frame_rx_if #(.BYTES_PER_FRAME(NB)) bus1 ();

    uart_frame_rx #(
        .CLOCKS_PER_BIT(CPB), .BYTES_PER_FRAME(NB), .PARITY_MODE(PARITY_NONE), .TIMEOUT_BITS(TO)
    ) dut0 (.clock(clock), .reset(reset), .bus(bus0.master));

    uart_frame_rx #(
        .CLOCKS_PER_BIT(CPB), .BYTES_PER_FRAME(NB), .PARITY_MODE(PARITY_EVEN), .TIMEOUT_BITS(TO)
    ) dut1 (.clock(clock), .reset(reset), .bus(bus1.master));

    // pulse monitors, sampled mid-cycle
    int fv_cnt[2], fe_cnt[2], pe_cnt[2], te_cnt[2], both_cnt[2], clash_cnt[2];
    int fv_cyc[2], te_cyc[2];
    int stop_cyc[2];

    always @(negedge clock) begin
        if (!reset) begin
            if (bus0.frame_valid)   begin fv_cnt[0] <= fv_cnt[0] + 1; fv_cyc[0] <= cyc; end
            if (bus0.framing_error) fe_cnt[0] <= fe_cnt[0] + 1;
            if (bus0.parity_error)  pe_cnt[0] <= pe_cnt[0] + 1;
            if (bus0.timeout_error) begin te_cnt[0] <= te_cnt[0] + 1; te_cyc[0] <= cyc; end
            if (bus0.framing_error && bus0.parity_error) both_cnt[0] <= both_cnt[0] + 1;
            if (bus0.frame_valid && (bus0.framing_error || bus0.parity_error || bus0.timeout_error))
                clash_cnt[0] <= clash_cnt[0] + 1;
            if (bus1.frame_valid)   begin fv_cnt[1] <= fv_cnt[1] + 1; fv_cyc[1] <= cyc; end
            if (bus1.framing_error) fe_cnt[1] <= fe_cnt[1] + 1;
            if (bus1.parity_error)  pe_cnt[1] <= pe_cnt[1] + 1;
            if (bus1.timeout_error) begin te_cnt[1] <= te_cnt[1] + 1; te_cyc[1] <= cyc; end
            if (bus1.framing_error && bus1.parity_error) both_cnt[1] <= both_cnt[1] + 1;
            if (bus1.frame_valid && (bus1.framing_error || bus1.parity_error || bus1.timeout_error))
                clash_cnt[1] <= clash_cnt[1] + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic set_rx(input int sel, input logic v);
        if (sel == 0) bus0.rx_serial = v;
        else          bus1.rx_serial = v;
    endtask

    // Called on a falling clock edge; holds the line level for one bit time.
    task automatic hold_bit(input int sel, input logic v);
        set_rx(sel, v);
        repeat (CPB) @(negedge clock);
    endtask

    task automatic send_byte(input int sel, input logic [7:0] d, input logic par_en,
                             input logic par_bit, input logic stop_v);
        hold_bit(sel, 1'b0);
        for (int i = 0; i < 8; i++) hold_bit(sel, d[i]);
        if (par_en) hold_bit(sel, par_bit);
        stop_cyc[sel] = cyc;
        hold_bit(sel, stop_v);
    endtask

    task automatic idle(input int sel, input int n);
        set_rx(sel, 1'b1);
        repeat (n) @(negedge clock);
    endtask

    int b_fv, b_fe, b_pe, b_te, b_both, t_stop, c0;
    logic [7:0] part;

    initial begin
        bus0.rx_serial = 1'b1;
        bus1.rx_serial = 1'b1;
        reset = 1'b1;
        repeat (3) @(negedge clock);
        check_eq("rst_frame_data", 32'(bus0.frame_data), 32'h0);
        check_eq("rst_frame_valid", 32'(bus0.frame_valid), 32'h0);
        check_eq("rst_busy", 32'(bus0.busy), 32'h0);
        check_eq("rst_errors", 32'({bus0.framing_error, bus0.parity_error, bus0.timeout_error}), 32'h0);
        check_eq("rst_state", 32'(bus0.dbg_state), 32'(IDLE));
        reset = 1'b0;
        repeat (4) @(negedge clock);

        // two back-to-back bytes form one frame; valid 3 cycles after mid-stop
        b_fv = fv_cnt[0];
        b_fe = fe_cnt[0] + pe_cnt[0] + te_cnt[0];
        send_byte(0, 8'hA5, 1'b0, 1'b0, 1'b1);
        send_byte(0, 8'h3C, 1'b0, 1'b0, 1'b1);
        idle(0, 2 * CPB);
        check_eq("t1_frame_data", 32'(bus0.frame_data), 32'hA53C);
        check_eq("t1_valid_pulses", 32'(fv_cnt[0] - b_fv), 32'd1);
        check_eq("t1_valid_cycle", 32'(fv_cyc[0]), 32'(stop_cyc[0] + 1 + CPB / 2 + 3));
        check_eq("t1_error_pulses", 32'(fe_cnt[0] + pe_cnt[0] + te_cnt[0] - b_fe), 32'd0);
        check_eq("t1_busy_after", 32'(bus0.busy), 32'h0);

        // bad stop bit discards the byte, next frame is clean
        b_fv = fv_cnt[0];
        b_fe = fe_cnt[0];
        send_byte(0, 8'h12, 1'b0, 1'b0, 1'b0);
        idle(0, 2 * CPB);
        check_eq("t2_framing_pulses", 32'(fe_cnt[0] - b_fe), 32'd1);
        check_eq("t2_no_valid", 32'(fv_cnt[0] - b_fv), 32'd0);
        check_eq("t2_data_held", 32'(bus0.frame_data), 32'hA53C);
        check_eq("t2_busy_after_err", 32'(bus0.busy), 32'h0);
        send_byte(0, 8'h34, 1'b0, 1'b0, 1'b1);
        send_byte(0, 8'h56, 1'b0, 1'b0, 1'b1);
        idle(0, 2 * CPB);
        check_eq("t2_frame_data", 32'(bus0.frame_data), 32'h3456);

        // 2-cycle glitch on an idle line
        b_fv = fv_cnt[0];
        b_fe = fe_cnt[0] + pe_cnt[0] + te_cnt[0];
        set_rx(0, 1'b0);
        repeat (2) @(negedge clock);
        set_rx(0, 1'b1);
        repeat (2) @(negedge clock);
        check_eq("t3_busy_during", 32'(bus0.busy), 32'h1);
        repeat (20) @(negedge clock);
        check_eq("t3_busy_after", 32'(bus0.busy), 32'h0);
        check_eq("t3_no_pulses", 32'(fv_cnt[0] - b_fv + fe_cnt[0] + pe_cnt[0] + te_cnt[0] - b_fe), 32'd0);

        // lone byte times out TO*CPB cycles after it is accepted
        b_fv = fv_cnt[0];
        b_te = te_cnt[0];
        send_byte(0, 8'h77, 1'b0, 1'b0, 1'b1);
        t_stop = stop_cyc[0];
        check_eq("t4_busy_between", 32'(bus0.busy), 32'h1);
        idle(0, 40);
        check_eq("t4_timeout_pulses", 32'(te_cnt[0] - b_te), 32'd1);
        check_eq("t4_timeout_cycle", 32'(te_cyc[0]), 32'(t_stop + 1 + CPB / 2 + 3 + TO * CPB));
        check_eq("t4_no_valid", 32'(fv_cnt[0] - b_fv), 32'd0);
        check_eq("t4_data_held", 32'(bus0.frame_data), 32'h3456);
        check_eq("t4_busy_after", 32'(bus0.busy), 32'h0);
        send_byte(0, 8'h01, 1'b0, 1'b0, 1'b1);
        send_byte(0, 8'h02, 1'b0, 1'b0, 1'b1);
        idle(0, 2 * CPB);
        check_eq("t4_frame_data", 32'(bus0.frame_data), 32'h0102);

        // even parity receiver
        b_fv = fv_cnt[1];
        b_pe = pe_cnt[1];
        b_fe = fe_cnt[1];
        b_both = both_cnt[1];
        send_byte(1, 8'h03, 1'b1, 1'b1, 1'b1);
        idle(1, 2 * CPB);
        check_eq("t5_parity_pulse", 32'(pe_cnt[1] - b_pe), 32'd1);
        check_eq("t5_no_framing", 32'(fe_cnt[1] - b_fe), 32'd0);
        send_byte(1, 8'h03, 1'b1, 1'b1, 1'b0);
        idle(1, 2 * CPB);
        check_eq("t5_both_same_cycle", 32'(both_cnt[1] - b_both), 32'd1);
        send_byte(1, 8'h03, 1'b1, 1'b0, 1'b1);
        send_byte(1, 8'h80, 1'b1, 1'b1, 1'b1);
        idle(1, 2 * CPB);
        check_eq("t5_frame_data", 32'(bus1.frame_data), 32'h0380);
        check_eq("t5_valid_pulses", 32'(fv_cnt[1] - b_fv), 32'd1);
        check_eq("t5_parity_total", 32'(pe_cnt[1] - b_pe), 32'd2);

        // reset in the middle of bit 4 of the second byte
        send_byte(0, 8'hC3, 1'b0, 1'b0, 1'b1);
        part = 8'h55;
        hold_bit(0, 1'b0);
        for (int i = 0; i < 4; i++) hold_bit(0, part[i]);
        set_rx(0, part[4]);
        repeat (3) @(negedge clock);
        check_eq("t6_busy_before", 32'(bus0.busy), 32'h1);
        #2 reset = 1'b1;
        #1;
        check_eq("t6_rst_frame_data", 32'(bus0.frame_data), 32'h0);
        check_eq("t6_rst_busy", 32'(bus0.busy), 32'h0);
        check_eq("t6_rst_state", 32'(bus0.dbg_state), 32'(IDLE));
        check_eq("t6_rst_pulses", 32'({bus0.frame_valid, bus0.framing_error, bus0.parity_error, bus0.timeout_error}), 32'h0);
        check_eq("t6_rst_other_data", 32'(bus1.frame_data), 32'h0);
        @(negedge clock);
        set_rx(0, 1'b1);
        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (4) @(negedge clock);
        b_fv = fv_cnt[0];
        c0 = fe_cnt[0] + pe_cnt[0] + te_cnt[0];
        send_byte(0, 8'hFF, 1'b0, 1'b0, 1'b1);
        send_byte(0, 8'h00, 1'b0, 1'b0, 1'b1);
        idle(0, 2 * CPB);
        check_eq("t6_frame_data", 32'(bus0.frame_data), 32'hFF00);
        check_eq("t6_valid_pulses", 32'(fv_cnt[0] - b_fv), 32'd1);
        check_eq("t6_no_errors", 32'(fe_cnt[0] + pe_cnt[0] + te_cnt[0] - c0), 32'd0);

        check_eq("valid_error_overlap0", 32'(clash_cnt[0]), 32'd0);
        check_eq("valid_error_overlap1", 32'(clash_cnt[1]), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_frame_rx.md
# uart_frame_rx

Parametrised multi-byte UART receiver that replaces the fixed single-frame receiver on the PC→FPGA link. Deserialises 8N1/8E1/8O1 bytes from `rx_serial` and assembles `BYTES_PER_FRAME` consecutive bytes into one command frame. Adds input synchronisation, start-bit glitch rejection, parity checking, stop-bit framing checks and an inter-byte timeout that discards partial frames. Sits between the RX pin and the command decoder/DHT11 control logic; `frame_data` feeds the byte splitter directly.

## Interface
- `CLOCKS_PER_BIT`, 5208, clock cycles per bit (50 MHz / 9600 baud); must be ≥ 4
- `BYTES_PER_FRAME`, 2, bytes per frame; must be ≥ 1
- `PARITY_MODE`, 0, 0 = none, 1 = even, 2 = odd
- `TIMEOUT_BITS`, 20, idle bit-times allowed between bytes of one frame
- `clock`  in  1  system clock; every register is clocked on its rising edge
- `reset`  in  1  asynchronous, active-high reset
- `rx_serial`  in  1  raw asynchronous serial line; idles high
- `frame_data`  out  8*BYTES_PER_FRAME  last complete frame; first received byte occupies the MS byte
- `frame_valid`  out  1  one-cycle pulse when `frame_data` updates
- `framing_error`  out  1  one-cycle pulse when a stop bit is sampled low
- `parity_error`  out  1  one-cycle pulse on a parity mismatch
- `timeout_error`  out  1  one-cycle pulse when a partial frame is discarded on timeout
- `busy`  out  1  high from start-bit detect until the frame completes, errors or times out

## Operation
- Input path: 2-flop synchroniser on `rx_serial`. Synchroniser flops reset to 1 (idle line).
- Byte FSM states and transitions:
  - IDLE → START on a synchronised falling edge.
  - START: wait `CLOCKS_PER_BIT/2` cycles (integer division), then sample the line.
    - Sampled low → DATA.
    - Sampled high → IDLE. Treated as a glitch: no error pulse, `byte_index` unchanged.
  - DATA: sample 8 bits, LSB first, one per `CLOCKS_PER_BIT` cycles. Then → PARITY if `PARITY_MODE` ≠ 0, else → STOP.
  - PARITY: sample one bit. Even mode expects the XOR of the data bits and the parity bit to be 0; odd mode expects 1. On mismatch, flag the byte for `parity_error`.
  - STOP: sample at mid-bit, then → IDLE immediately, so a following start edge is accepted half a bit early.
- Outcome of the stop-bit sample:
  - Stop bit low → `framing_error` pulse. Partial frame discarded, `byte_index` ← 0.
  - Parity flagged → `parity_error` pulse. Partial frame discarded, `byte_index` ← 0. If the stop bit is also low, both error pulses fire in the same cycle.
  - Otherwise the byte shifts into the frame shift register and `byte_index` increments.
- When `byte_index` reaches `BYTES_PER_FRAME`: copy the shift register to `frame_data`, pulse `frame_valid`, and set `byte_index` ← 0.
- Timeout:
  - While in IDLE with `byte_index` > 0, count cycles. The counter restarts on every accepted byte.
  - At `TIMEOUT_BITS*CLOCKS_PER_BIT` cycles → `timeout_error` pulse, `byte_index` ← 0.
  - A start edge seen in the same cycle as the timeout is still accepted, as byte 0 of a new frame.
- `frame_data` holds its value until the next complete frame; error and timeout events never alter it.
- Counter widths: `$clog2(CLOCKS_PER_BIT)` for the bit timer, `$clog2(TIMEOUT_BITS*CLOCKS_PER_BIT+1)` for the timeout counter, `$clog2(BYTES_PER_FRAME+1)` for `byte_index`.

## Timing
- Reset (asynchronous, any state):
  - All outputs go to 0 and the FSM goes to IDLE.
  - Shift register, `byte_index` and all counters are cleared.
  - A byte in flight is lost. Reception resumes on the next falling edge after `reset` deasserts.
- Latency: `frame_valid` rises on the clock edge after the mid-stop-bit sample of the final byte. Including the synchroniser, that is 2 + 1 cycles after the true mid-stop point.
- Pulse outputs are registered and exactly one cycle wide. `frame_valid` and any error pulse are never high in the same cycle.
- `busy`: rises on the cycle START is entered. It falls in the same cycle as `frame_valid`, an error pulse, `timeout_error`, or a glitch return to IDLE with `byte_index` = 0. It stays high between bytes of one frame.
- Minimum frame period = `BYTES_PER_FRAME * (9.5 + parity) * CLOCKS_PER_BIT` cycles. Back-to-back frames with no idle gap are received without loss.

## Structure
- Shared package `uart_pkg` holds:
  - the FSM state enum (IDLE, START, DATA, PARITY, STOP);
  - the `PARITY_NONE`/`PARITY_EVEN`/`PARITY_ODD` constants;
  - the baud constant for 50 MHz / 9600.
- One natural sub-module, `uart_rx_byte`, handles the synchroniser, byte FSM, bit timer and parity/stop checks. It outputs `byte_done`, `byte_data`, `frame_err` and `par_err`.
- The top module owns frame assembly, `byte_index`, the timeout counter and the output pulses. The next-generation `uart_frame_tx` reuses `uart_pkg`.

## Test plan
All scenarios use `CLOCKS_PER_BIT`=8, `BYTES_PER_FRAME`=2, `TIMEOUT_BITS`=4 unless stated.
- Send 0xA5 then 0x3C, 8N1 → `frame_data`=16'hA53C, a single `frame_valid` pulse 3 cycles after the mid-stop point, no error pulses.
- Send 0x12 with its stop bit low, then 0x34, 0x56 → one `framing_error` pulse, no `frame_valid` for 0x12. The following frame gives `frame_data`=16'h3456.
- Drive a 2-cycle low glitch on an idle line → no pulses, `busy` returns low.
- Send 0x77, then idle 40 cycles → `timeout_error` at 32 idle cycles. Then send 0x01, 0x02 → `frame_data`=16'h0102.
- `PARITY_MODE`=1: send 0x03 with parity bit 1 → `parity_error` pulse. Send 0x03 with parity bit 0, then 0x80 with parity bit 1 → `frame_data`=16'h0380.
- Assert `reset` during bit 4 of byte 2 → all outputs 0 immediately. After release, sending 0xFF, 0x00 gives `frame_data`=16'hFF00.
